alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the combinational datapath ALU. It accepts one operation per transfer on a valid/ready input channel and returns a registered result plus flags on a valid/ready output channel. Single-cycle ops have one cycle of latency. Multiply ops run on an iterative shift-add engine. It sits between the issue stage and writeback, and supplies backpressure when writeback stalls.

## Interface
- WIDTH, 32: operand/result width; power of two, 8..64
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  block can accept request this cycle
- in_op  in  4  operation code (see Operation)
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- out_result  out  WIDTH  result
- out_flags  out  4  {ovf, carry, neg, zero}
- out_err  out  1  in_op was reserved (15)

## Operation
- Op codes: 0 Add, 1 Sub, 2 And, 3 Or, 4 Xor, 5 Not(~a), 6 Sll, 7 Srl, 8 Sra, 9 Eq, 10 Neq, 11 Slt (signed), 12 Sltu, 13 Mul (low WIDTH bits of a*b), 14 Mulhu (high WIDTH bits of unsigned 2*WIDTH product), 15 reserved.
- Shifts use b[SHW-1:0] only. Eq/Neq/Slt/Sltu produce 1 or 0, zero-extended.
- Reserved op: result 0, flags 0, out_err=1. It is otherwise treated as a single-cycle op. out_err is 0 for every other op.
- Flag rules:
  - zero = (result==0) and neg = result[WIDTH-1], for all ops.
  - Add: carry = carry-out of a+b; ovf = signed overflow.
  - Sub: carry = NOT borrow, i.e. a>=b unsigned; ovf = signed overflow of a-b.
  - All other ops: carry=0, ovf=0.
- Transfers:
  - An input transfer occurs when in_valid & in_ready at a rising edge.
  - An output transfer occurs when out_valid & out_ready at a rising edge.
- in_ready = !rst & (state==IDLE) & (!out_valid | out_ready). It depends combinationally on out_ready only; there is no combinational path from in_* to out_*.
- States:
  - IDLE:
    - On a single-cycle accept, load the output register; out_valid=1 next cycle; stay in IDLE.
    - On a Mul/Mulhu accept, latch a, b and op; clear the 2*WIDTH accumulator; counter=0; go to BUSY.
  - BUSY:
    - Each cycle, if b_shift[0], add (a zero-extended, shifted left by counter) into the accumulator. Shift b_shift right by 1; counter+1. in_ready=0.
    - When counter reaches WIDTH, go to WRITE.
  - WRITE:
    - If !out_valid or out_ready: load out_result from the accumulator, low half for Mul and high half for Mulhu; set flags; out_valid=1; go to IDLE.
    - Otherwise wait in WRITE.
- Output register holds result, flags and err stable while out_valid & !out_ready.
- out_valid clears after an output transfer unless it is reloaded in the same cycle.
- Reset mid-BUSY abandons the operation; no result is produced.

## Timing
- Reset values: out_valid=0, out_result=0, out_flags=0, out_err=0, state=IDLE, counter=0, accumulator=0. in_ready=0 while rst is high and 1 on the first cycle after release.
- Single-cycle op: accepted at edge E, out_valid high after E. Full throughput of 1 op/cycle when out_ready is held high.
- Mul/Mulhu: accepted at E. BUSY steps occur at E+1..E+WIDTH; output loads at E+WIDTH+1 when the output slot is free. Latency is WIDTH+1 cycles. in_ready is low from after E until back in IDLE.
- Simultaneous output transfer and new input accept in the same cycle is allowed: the old result leaves and the new one loads at that edge.
- Stalled output (out_ready=0, out_valid=1): in_ready=0, and no input is accepted.

## Test plan
- Reset mid-traffic: assert rst during BUSY -> outputs immediately 0. After release, in_ready=1, no stale result appears, and the next Add 2+3 returns 5.
- Back-to-back with out_ready=1, WIDTH=32: Add 0xFFFFFFFF+1, Sub 3-5, Sra 0x80000000 by 4, Slt -1<1 -> results 0x0, 0xFFFFFFFE, 0xF8000000, 1 on consecutive cycles.
  - Flags: Add zero=1, carry=1, ovf=0; Sub neg=1, carry=0.
- Overflow and shift masking: Add 0x7FFFFFFF+1 -> 0x80000000 with ovf=1, neg=1. Sll 1 by b=33 -> 2.
- Multiply: Mul 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. Mulhu on the same operands -> 0xFFFFFFFE. out_valid appears exactly 33 cycles after accept, and in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after an Xor 0xF0F0^0x0FF0 -> out_result stays 0xFF00 with out_valid high, in_ready=0, and no accept. Releasing out_ready with in_valid high gives transfer-out and accept on the same edge.
- Reserved op 15 -> out_result=0, out_err=1 for one result. The following Eq 7==7 -> 1 with out_err=0.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops return one cycle after accept,
// Mul/Mulhu run on an iterative shift-add engine over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_EQ    = 4'd9;
  localparam logic [3:0] OP_NEQ   = 4'd10;
  localparam logic [3:0] OP_SLT   = 4'd11;
  localparam logic [3:0] OP_SLTU  = 4'd12;
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [3:0] OP_MULHU = 4'd14;

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, WRITE} state_t;

  state_t             state;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic               mhi;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_carry;
  logic               sc_ovf;
  logic               sc_err;
  logic [3:0]         sc_flags;
  logic               is_mul;
  logic               accept;
  logic [SHW:0]       cnt_inc;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mul_res;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high; ready never depends on the same-side valid.
  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (in_op == OP_MUL) || (in_op == OP_MULHU);

  assign sum     = {1'b0, in_a} + {1'b0, in_b};
  assign diff    = in_a - in_b;
  assign sh      = in_b[SHW-1:0];
  assign cnt_inc = cnt + CNT_ONE;
  assign addend  = {{WIDTH{1'b0}}, ma} << cnt;
  assign mul_res = mhi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    case (in_op)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff;
        sc_carry = (in_a >= in_b);
        sc_ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  sc_res = in_a & in_b;
      OP_OR:   sc_res = in_a | in_b;
      OP_XOR:  sc_res = in_a ^ in_b;
      OP_NOT:  sc_res = ~in_a;
      OP_SLL:  sc_res = in_a << sh;
      OP_SRL:  sc_res = in_a >> sh;
      OP_SRA:  sc_res = $signed(in_a) >>> sh;
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      OP_NEQ:  sc_res = {{(WIDTH-1){1'b0}}, (in_a != in_b)};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_MUL, OP_MULHU: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
    // The reserved op reports all-zero flags, including zero.
    if (sc_err) sc_flags = 4'b0000;
    else        sc_flags = {sc_ovf, sc_carry, sc_res[WIDTH-1], (sc_res == '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      ma         <= '0;
      mb         <= '0;
      mhi        <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= 4'b0000;
      out_err    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              ma    <= in_a;
              mb    <= in_b;
              mhi   <= (in_op == OP_MULHU);
              acc   <= '0;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              out_result <= sc_res;
              out_flags  <= sc_flags;
              out_err    <= sc_err;
              out_valid  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mb[0]) acc <= acc + addend;
          mb  <= mb >> 1;
          cnt <= cnt_inc;
          if (cnt_inc == CNT_END) state <= WRITE;
        end
        WRITE: begin
          // Hold the finished product until the output slot frees up.
          if (!out_valid || out_ready) begin
            out_result <= mul_res;
            out_flags  <= {2'b00, mul_res[WIDTH-1], (mul_res == '0)};
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
